key_event_reader: RTL
=====================

# key_event_reader

Input-side counterpart to the LED output path. It samples the four active-low board keys, synchronises and debounces each one, and detects press and release transitions. Each transition is queued as an event in a small FIFO, and a downstream controller (for example an LED pattern sequencer) drains the FIFO over a valid/ready handshake. The whole block runs on the single board clock; the debounce time base is a one-cycle enable strobe, not a derived clock.

## Interface
- CLK_DIV_PERIOD, 12_000: clk cycles per debounce tick (1 ms at 12 MHz); 2..2^25.
- DELAY, 10: consecutive disagreeing ticks needed to accept a key change; 2..15.
- DEPTH, 4: event FIFO depth, power of two, 2..16.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key  in  [0:3]  raw keys, 0 = pressed.
- key_state  out  [0:3]  debounced level, 0 = pressed.
- evt_valid  out  1  FIFO head holds an event.
- evt_key  out  2  key index of the head event.
- evt_press  out  1  1 = press (1->0), 0 = release (0->1).
- evt_ready  in  1  consumer accepts the head event.
- ovf  out  1  sticky flag: an event was lost.
- ovf_clr  in  1  clears ovf.

## Operation
- **Synchroniser:** two-flop synchroniser per key, reset value 1.
- **Tick:** 25-bit counter runs 0..CLK_DIV_PERIOD-1 and wraps. tick = 1 for one cycle when count == CLK_DIV_PERIOD-1.
- **Debounce, per key:** 4-bit counter, advanced only on tick.
  - Synced sample == key_state: counter cleared.
  - Sample differs and counter == DELAY-1: key_state flips, counter cleared, pending flag for that key is set with polarity.
  - Sample differs otherwise: counter increments.
  - Net effect: a change is accepted on the DELAY-th consecutive disagreeing tick. Any agreeing tick restarts the count.
- **Pending, per key:** holds one event (polarity bit).
  - If a key flips while its pending flag is still set, the pending polarity is overwritten with the new one and ovf is set.
- **Arbiter:** each cycle, pushes the lowest-index pending event into the FIFO if a push is allowed, then clears that pending flag.
  - One push per cycle.
- **FIFO:** first-word-fall-through, DEPTH entries of {key[1:0], press}.
  - evt_valid = not empty. evt_key and evt_press show the head entry.
  - Pop when evt_valid && evt_ready.
  - Push allowed when count < DEPTH, or when full and a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- **Back-pressure:** while the FIFO is full, events wait in their pending flags. Loss occurs only through a pending overwrite, which sets ovf.
- **ovf:** cleared by ovf_clr. If a set event and ovf_clr happen in the same cycle, set wins.
- **Handshake rule:** evt_valid, evt_key and evt_press must not change while evt_valid = 1 and evt_ready = 0.
- **Reset (asserted at any time):**
  - key_state = 4'b1111.
  - All counters, pending flags and FIFO pointers = 0.
  - evt_valid = 0, evt_key = 0, evt_press = 0, ovf = 0.
  - Queued and pending events are discarded.
  - After release, the tick counter restarts from 0.

## Timing
- Raw edge to key_state change:
  - at least 2 + (DELAY-1)*CLK_DIV_PERIOD + 1 cycles;
  - at most 2 + DELAY*CLK_DIV_PERIOD cycles.
- key_state flips at clock edge E; pending is set at E.
- With the FIFO not full, the push happens at E+1, so evt_valid rises 1 cycle after key_state changes.
- Simultaneous flips of N keys at E: pushes at E+1..E+N in key-index order.
- Pop at edge P: the next entry is visible at P with no bubble. Empty after the last pop means evt_valid = 0 after P.
- Push into an empty FIFO at edge E+1: evt_valid = 1 immediately after E+1.

## Test plan
Bench parameters: CLK_DIV_PERIOD = 4, DELAY = 3, DEPTH = 4.
- **Clean press:** reset, then key[0] driven 1->0 and held 40 cycles, evt_ready = 1 -> key_state[0] = 0 within 14 cycles of the edge; exactly one event {0, press = 1}; evt_valid high for 1 cycle.
- **Bounce:** key[1] toggles every 5 cycles for 60 cycles, then held 0 -> no event during the toggling; exactly one press event for key 1 after it settles.
- **Simultaneous:** key[3] and key[0] pressed on the same cycle -> two events on consecutive cycles, key 0 first, then key 3.
- **Back-pressure:** evt_ready = 0, keys 0..3 each pressed and released sequentially -> FIFO holds 4; remaining events held pending; ovf = 1 after key 0 flips again while its event is still pending; evt_ready = 1 drains the events in order; ovf_clr -> ovf = 0.
- **Full with concurrent pop:** FIFO full and a pending push in the same cycle as a pop -> the push is accepted that cycle and count stays at 4.
- **Reset mid-operation:** rst low while 2 events are queued and 1 is pending -> evt_valid = 0, key_state = 4'b1111, ovf = 0; no stale events appear after release.

Source files
------------

// File: rtl/key_event_reader.sv
// Board key input path: synchronise and debounce four active-low keys, turn each
// accepted level change into a press/release event and queue it for a valid/ready consumer.
module key_event_reader #(
  parameter int unsigned CLK_DIV_PERIOD = 12_000,
  parameter int unsigned DELAY          = 10,
  parameter int unsigned DEPTH          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:3] key,
  output logic [0:3] key_state,
  output logic       evt_valid,
  output logic [1:0] evt_key,
  output logic       evt_press,
  input  logic       evt_ready,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [24:0] TICK_LAST = 25'(CLK_DIV_PERIOD - 1);
  localparam logic [3:0]  CNT_LAST  = 4'(DELAY - 1);

  typedef struct packed {
    logic [1:0] idx;
    logic       press;
  } evt_t;

  logic [0:3]    key_meta;
  logic [0:3]    key_sync;
  logic [24:0]   tick_cnt;
  logic          tick;
  logic [3:0]    db_cnt [4];
  logic [3:0]    flip;
  logic [3:0]    pend_valid;
  logic [3:0]    pend_press;
  logic [3:0]    push_mask;
  logic [1:0]    arb_idx;
  logic          arb_any;
  logic          push;
  logic          pop;
  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  evt_t          head;

  // Two-flop synchroniser; idle level is "released".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 25'd1;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    flip = '0;
    for (int i = 0; i < 4; i++)
      flip[i] = tick && (key_sync[i] != key_state[i]) && (db_cnt[i] == CNT_LAST);
  end

  // NOTE: sequential state uses <= so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_state <= '1;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (key_sync[i] == key_state[i]) begin
          db_cnt[i] <= '0;
        end else if (flip[i]) begin
          db_cnt[i]    <= '0;
          key_state[i] <= ~key_state[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Lowest key index wins: the loop runs downward so the last hit is the smallest index.
  always_comb begin
    arb_any = 1'b0;
    arb_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_valid[i]) begin
        arb_any = 1'b1;
        arb_idx = 2'(i);
      end
    end
  end

  assign pop  = evt_valid && evt_ready;
  assign push = arb_any && ((count < DEPTH_C) || pop);

  always_comb begin
    push_mask = '0;
    if (push) push_mask[arb_idx] = 1'b1;
  end

  // A flip landing on a pending slot that is being pushed this cycle loses nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= '0;
      pend_press <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (flip[i]) begin
          pend_valid[i] <= 1'b1;
          pend_press[i] <= key_state[i];
        end else if (push_mask[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  ovf <= 1'b0;
    else if (|(flip & pend_valid & ~push_mask)) ovf <= 1'b1;
    else if (ovf_clr)                          ovf <= 1'b0;
  end

  // NOTE: storage has no reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {arb_idx, pend_press[arb_idx]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head is gated so the outputs read zero whenever nothing is queued.
  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_key   = evt_valid ? head.idx : 2'd0;
  assign evt_press = evt_valid ? head.press : 1'b0;

endmodule
